// File: rtl/cram_arbiter_if.sv
// rtl/cram_arbiter_if.sv - requester, RAM and optional statistics signals of cram_arbiter
// Optional statistics outputs exist only when CRAM_ARB_STATS_EN is defined.
interface cram_arbiter_if #(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10
);
  logic                       i_w_req_0;
  logic                       i_w_we_0;
  logic [p_address_width-1:0] i_w_address_0;
  logic [p_data_width-1:0]    i_w_in_0;
  logic                       o_r_gnt_0;
  logic                       o_r_rvalid_0;
  logic                       i_w_req_1;
  logic                       i_w_we_1;
  logic [p_address_width-1:0] i_w_address_1;
  logic [p_data_width-1:0]    i_w_in_1;
  logic                       o_r_gnt_1;
  logic                       o_r_rvalid_1;
  logic [p_data_width-1:0]    o_w_rdata;
  logic [p_address_width-1:0] o_r_ram_address;
  logic [p_data_width-1:0]    o_r_ram_in;
  logic                       o_r_ram_we;
  logic                       o_r_ram_oe;
  logic [p_data_width-1:0]    i_w_ram_out;
`ifdef CRAM_ARB_STATS_EN
  logic [15:0]                o_r_gnt_count_0;
  logic [15:0]                o_r_gnt_count_1;
`endif

  // master: requesters plus the cram instance; slave: the arbiter
  modport master (
    output i_w_req_0, i_w_we_0, i_w_address_0, i_w_in_0,
    output i_w_req_1, i_w_we_1, i_w_address_1, i_w_in_1,
    output i_w_ram_out,
    input  o_r_gnt_0, o_r_rvalid_0, o_r_gnt_1, o_r_rvalid_1,
    input  o_w_rdata, o_r_ram_address, o_r_ram_in, o_r_ram_we, o_r_ram_oe
`ifdef CRAM_ARB_STATS_EN
    , input o_r_gnt_count_0, o_r_gnt_count_1
`endif
  );

  modport slave (
    input  i_w_req_0, i_w_we_0, i_w_address_0, i_w_in_0,
    input  i_w_req_1, i_w_we_1, i_w_address_1, i_w_in_1,
    input  i_w_ram_out,
    output o_r_gnt_0, o_r_rvalid_0, o_r_gnt_1, o_r_rvalid_1,
    output o_w_rdata, o_r_ram_address, o_r_ram_in, o_r_ram_we, o_r_ram_oe
`ifdef CRAM_ARB_STATS_EN
    , output o_r_gnt_count_0, o_r_gnt_count_1
`endif
  );
endinterface

// File: rtl/cram_arbiter.sv
// rtl/cram_arbiter.sv - two-requester round-robin arbiter for the single-port control RAM
// Optional per-requester saturating grant counters: CRAM_ARB_STATS_EN.
module cram_arbiter #(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10
) (
  input logic          i_w_clk,
  input logic          i_w_reset,
  cram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, READ_DATA} state_t;

  state_t state;
  logic   priority_ptr;
  logic   winner;
  logic   write_q;
  logic   pick;

  // With both requesting the pointer decides; otherwise whoever asks wins.
  always_comb begin
    pick = 1'b0;
    if (bus.i_w_req_0 && bus.i_w_req_1) pick = priority_ptr;
    else if (bus.i_w_req_1)             pick = 1'b1;
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state               <= IDLE;
      priority_ptr        <= 1'b0;
      winner              <= 1'b0;
      write_q             <= 1'b0;
      bus.o_r_gnt_0       <= 1'b0;
      bus.o_r_gnt_1       <= 1'b0;
      bus.o_r_rvalid_0    <= 1'b0;
      bus.o_r_rvalid_1    <= 1'b0;
      bus.o_r_ram_address <= '0;
      bus.o_r_ram_in      <= '0;
      bus.o_r_ram_we      <= 1'b0;
      bus.o_r_ram_oe      <= 1'b0;
    end else begin
      bus.o_r_gnt_0    <= 1'b0;
      bus.o_r_gnt_1    <= 1'b0;
      bus.o_r_rvalid_0 <= 1'b0;
      bus.o_r_rvalid_1 <= 1'b0;
      bus.o_r_ram_we   <= 1'b0;
      bus.o_r_ram_oe   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_w_req_0 || bus.i_w_req_1) begin
            winner              <= pick;
            write_q             <= pick ? bus.i_w_we_1 : bus.i_w_we_0;
            bus.o_r_ram_address <= pick ? bus.i_w_address_1 : bus.i_w_address_0;
            bus.o_r_ram_in      <= pick ? bus.i_w_in_1 : bus.i_w_in_0;
            bus.o_r_ram_we      <= pick ? bus.i_w_we_1 : bus.i_w_we_0;
            bus.o_r_ram_oe      <= pick ? !bus.i_w_we_1 : !bus.i_w_we_0;
            bus.o_r_gnt_0       <= !pick;
            bus.o_r_gnt_1       <= pick;
            state               <= ACCESS;
          end
        end
        ACCESS: begin
          priority_ptr <= !winner;
          if (write_q) begin
            state <= IDLE;
          end else begin
            // Keep oe up while the RAM's registered output is consumed.
            bus.o_r_ram_oe   <= 1'b1;
            bus.o_r_rvalid_0 <= !winner;
            bus.o_r_rvalid_1 <= winner;
            state            <= READ_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_w_rdata = (state == READ_DATA) ? bus.i_w_ram_out : '0;

`ifdef CRAM_ARB_STATS_EN
  logic [15:0] gnt_count_0_q;
  logic [15:0] gnt_count_1_q;

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      gnt_count_0_q <= 16'h0000;
      gnt_count_1_q <= 16'h0000;
    end else begin
      if (bus.o_r_gnt_0 && gnt_count_0_q != 16'hFFFF) gnt_count_0_q <= gnt_count_0_q + 16'd1;
      if (bus.o_r_gnt_1 && gnt_count_1_q != 16'hFFFF) gnt_count_1_q <= gnt_count_1_q + 16'd1;
    end
  end

  assign bus.o_r_gnt_count_0 = gnt_count_0_q;
  assign bus.o_r_gnt_count_1 = gnt_count_1_q;
`endif
endmodule

// File: tb/tb_cram_arbiter.sv
// tb/tb_cram_arbiter.sv - directed self-checking bench for cram_arbiter with a behavioural cram
module tb_cram_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  cram_arbiter_if #(.p_data_width(16), .p_address_width(10)) bus ();

  cram_arbiter #(.p_data_width(16), .p_address_width(10)) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.o_r_ram_oe) bus.i_w_ram_out <= mem[bus.o_r_ram_address];
    if (bus.o_r_ram_we) mem[bus.o_r_ram_address] <= bus.o_r_ram_in;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.i_w_req_0 = 1'b0; bus.i_w_we_0 = 1'b0; bus.i_w_address_0 = '0; bus.i_w_in_0 = '0;
    bus.i_w_req_1 = 1'b0; bus.i_w_we_1 = 1'b0; bus.i_w_address_1 = '0; bus.i_w_in_1 = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_write(input bit id, input logic [9:0] a, input logic [15:0] d);
    if (id) begin
      bus.i_w_req_1 = 1'b1; bus.i_w_we_1 = 1'b1; bus.i_w_address_1 = a; bus.i_w_in_1 = d;
    end else begin
      bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b1; bus.i_w_address_0 = a; bus.i_w_in_0 = d;
    end
    tick();
    clear_reqs();
    tick();
  endtask

  task automatic test_reset();
    int bad;
    clear_reqs();
    apply_reset();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({bus.o_r_gnt_0, bus.o_r_gnt_1, bus.o_r_rvalid_0, bus.o_r_rvalid_1,
           bus.o_r_ram_we, bus.o_r_ram_oe} !== 6'b0) bad++;
      if (bus.o_w_rdata !== 16'h0) bad++;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL reset_idle: got %0d nonzero samples want 0", bad); end
    n_cmp++;
    if (bus.o_r_ram_address !== 10'h0 || bus.o_r_ram_in !== 16'h0) begin
      n_bad++; $display("FAIL reset_regs: got addr %h in %h want 0 0", bus.o_r_ram_address, bus.o_r_ram_in);
    end
  endtask

  task automatic test_write_read();
    bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b1; bus.i_w_address_0 = 10'h005; bus.i_w_in_0 = 16'hBEEF;
    tick();
    n_cmp++;
    if ({bus.o_r_gnt_0, bus.o_r_gnt_1, bus.o_r_ram_we, bus.o_r_ram_oe} !== 4'b1010) begin
      n_bad++; $display("FAIL wr_access: got gnt0,gnt1,we,oe=%b%b%b%b want 1010",
                        bus.o_r_gnt_0, bus.o_r_gnt_1, bus.o_r_ram_we, bus.o_r_ram_oe);
    end
    n_cmp++;
    if (bus.o_r_ram_address !== 10'h005 || bus.o_r_ram_in !== 16'hBEEF) begin
      n_bad++; $display("FAIL wr_fields: got %h/%h want 005/beef", bus.o_r_ram_address, bus.o_r_ram_in);
    end
    clear_reqs();
    tick();
    n_cmp++;
    if ({bus.o_r_gnt_0, bus.o_r_ram_we, bus.o_r_rvalid_0} !== 3'b000) begin
      n_bad++; $display("FAIL wr_done: got gnt0,we,rvalid0=%b%b%b want 000",
                        bus.o_r_gnt_0, bus.o_r_ram_we, bus.o_r_rvalid_0);
    end
    bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b0; bus.i_w_address_0 = 10'h005;
    tick();
    n_cmp++;
    if ({bus.o_r_gnt_0, bus.o_r_ram_we, bus.o_r_ram_oe, bus.o_r_rvalid_0} !== 4'b1010) begin
      n_bad++; $display("FAIL rd_access: got gnt0,we,oe,rvalid0=%b%b%b%b want 1010",
                        bus.o_r_gnt_0, bus.o_r_ram_we, bus.o_r_ram_oe, bus.o_r_rvalid_0);
    end
    clear_reqs();
    tick();
    n_cmp++;
    if (bus.o_r_rvalid_0 !== 1'b1 || bus.o_r_rvalid_1 !== 1'b0 || bus.o_w_rdata !== 16'hBEEF) begin
      n_bad++; $display("FAIL rd_data: got rvalid0 %b rvalid1 %b rdata %h want 1 0 beef",
                        bus.o_r_rvalid_0, bus.o_r_rvalid_1, bus.o_w_rdata);
    end
    tick();
    n_cmp++;
    if (bus.o_r_rvalid_0 !== 1'b0 || bus.o_w_rdata !== 16'h0 || bus.o_r_ram_oe !== 1'b0) begin
      n_bad++; $display("FAIL rd_end: got rvalid0 %b rdata %h oe %b want 0 0000 0",
                        bus.o_r_rvalid_0, bus.o_w_rdata, bus.o_r_ram_oe);
    end
  endtask

  task automatic test_simultaneous();
    do_write(1'b0, 10'h001, 16'h1111);
    do_write(1'b1, 10'h002, 16'h2222);
    apply_reset();
    bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b0; bus.i_w_address_0 = 10'h001;
    bus.i_w_req_1 = 1'b1; bus.i_w_we_1 = 1'b0; bus.i_w_address_1 = 10'h002;
    tick();
    n_cmp++;
    if (bus.o_r_gnt_0 !== 1'b1 || bus.o_r_gnt_1 !== 1'b0) begin
      n_bad++; $display("FAIL sim_first: got gnt0 %b gnt1 %b want 1 0", bus.o_r_gnt_0, bus.o_r_gnt_1);
    end
    bus.i_w_req_0 = 1'b0;
    tick();
    n_cmp++;
    if (bus.o_r_rvalid_0 !== 1'b1 || bus.o_r_rvalid_1 !== 1'b0 || bus.o_w_rdata !== 16'h1111) begin
      n_bad++; $display("FAIL sim_rdata0: got rvalid0 %b rvalid1 %b rdata %h want 1 0 1111",
                        bus.o_r_rvalid_0, bus.o_r_rvalid_1, bus.o_w_rdata);
    end
    tick();
    n_cmp++;
    if (bus.o_r_gnt_0 !== 1'b0 || bus.o_r_gnt_1 !== 1'b0) begin
      n_bad++; $display("FAIL sim_no_pipe: got gnt0 %b gnt1 %b want 0 0", bus.o_r_gnt_0, bus.o_r_gnt_1);
    end
    tick();
    n_cmp++;
    if (bus.o_r_gnt_0 !== 1'b0 || bus.o_r_gnt_1 !== 1'b1) begin
      n_bad++; $display("FAIL sim_second: got gnt0 %b gnt1 %b want 0 1", bus.o_r_gnt_0, bus.o_r_gnt_1);
    end
    bus.i_w_req_1 = 1'b0;
    tick();
    n_cmp++;
    if (bus.o_r_rvalid_1 !== 1'b1 || bus.o_r_rvalid_0 !== 1'b0 || bus.o_w_rdata !== 16'h2222) begin
      n_bad++; $display("FAIL sim_rdata1: got rvalid1 %b rvalid0 %b rdata %h want 1 0 2222",
                        bus.o_r_rvalid_1, bus.o_r_rvalid_0, bus.o_w_rdata);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_back_to_back();
    bit seq [8];
    int got;
    int bad_excl;
    apply_reset();
    bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b1; bus.i_w_address_0 = 10'h010; bus.i_w_in_0 = 16'h5555;
    bus.i_w_req_1 = 1'b1; bus.i_w_we_1 = 1'b0; bus.i_w_address_1 = 10'h020;
    got = 0;
    bad_excl = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      tick();
      if (bus.o_r_gnt_0 && bus.o_r_gnt_1) bad_excl++;
      if (bus.o_r_rvalid_0 && bus.o_r_rvalid_1) bad_excl++;
      if (bus.o_r_ram_we && bus.o_r_ram_oe) bad_excl++;
      if (bus.o_r_gnt_0 || bus.o_r_gnt_1) begin
        seq[got] = bus.o_r_gnt_1;
        got++;
      end
    end
    clear_reqs();
    tick(); tick(); tick();
    n_cmp++;
    if (got !== 8) begin n_bad++; $display("FAIL rr_count: got %0d grants want 8 within bound", got); end
    n_cmp++;
    if (bad_excl !== 0) begin n_bad++; $display("FAIL rr_exclusive: got %0d overlaps want 0", bad_excl); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i < got && seq[i] !== 1'(i % 2)) begin
        n_bad++; $display("FAIL rr_order[%0d]: got requester %0d want %0d", i, seq[i], i % 2);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int bad;
    do_write(1'b0, 10'h3FF, 16'hA5A5);
    bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b1; bus.i_w_address_0 = 10'h3FF; bus.i_w_in_0 = 16'h1234;
    tick();
    n_cmp++;
    if (bus.o_r_ram_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we: got %b want 1", bus.o_r_ram_we); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.o_r_ram_we !== 1'b0 || bus.o_r_gnt_0 !== 1'b0) begin
      n_bad++; $display("FAIL rst_async: got we %b gnt0 %b want 0 0", bus.o_r_ram_we, bus.o_r_gnt_0);
    end
    clear_reqs();
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({bus.o_r_gnt_0, bus.o_r_gnt_1, bus.o_r_rvalid_0, bus.o_r_rvalid_1, bus.o_r_ram_we} !== 5'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL rst_quiet: got %0d active samples want 0", bad); end
    bus.i_w_req_0 = 1'b1; bus.i_w_we_0 = 1'b0; bus.i_w_address_0 = 10'h3FF;
    tick();
    clear_reqs();
    tick();
    n_cmp++;
    if (bus.o_r_rvalid_0 !== 1'b1 || bus.o_w_rdata !== 16'hA5A5) begin
      n_bad++; $display("FAIL rst_prior_data: got rvalid0 %b rdata %h want 1 a5a5",
                        bus.o_r_rvalid_0, bus.o_w_rdata);
    end
    tick();
  endtask

`ifdef CRAM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 5; i++) do_write(1'b0, 10'(i), 16'h0);
    for (int i = 0; i < 3; i++) do_write(1'b1, 10'(i), 16'h0);
    n_cmp++;
    if (bus.o_r_gnt_count_0 !== 16'd5 || bus.o_r_gnt_count_1 !== 16'd3) begin
      n_bad++; $display("FAIL stats_count: got %0d/%0d want 5/3", bus.o_r_gnt_count_0, bus.o_r_gnt_count_1);
    end
    dut.gnt_count_0_q = 16'hFFFE;
    for (int i = 0; i < 3; i++) do_write(1'b0, 10'(i), 16'h0);
    n_cmp++;
    if (bus.o_r_gnt_count_0 !== 16'hFFFF) begin
      n_bad++; $display("FAIL stats_saturate: got %h want ffff", bus.o_r_gnt_count_0);
    end
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    clear_reqs();
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
`ifdef CRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cram_arbiter.md
Name: cram_arbiter

Overview:
Two-requester round-robin arbiter that shares the single-port control RAM (cram/block_ram, 1-cycle registered read latency) between requester 0 (CPU datapath) and requester 1 (I/O / DMA master).
- Latches the winning request.
- Drives the RAM address, data, write-enable and output-enable strobes.
- Returns read data with a one-cycle valid pulse.
- Sits between the requesters and the cram instance; it is the only driver of the cram ports.

Parameters:
p_data_width, 16, RAM word width
p_address_width, 10, RAM address width

Ports:
i_w_clk  input  1  system clock, rising edge
i_w_reset  input  1  asynchronous reset, active-high
i_w_req_0  input  1  requester 0 access request
i_w_we_0  input  1  requester 0 write (1) / read (0)
i_w_address_0  input  p_address_width  requester 0 address
i_w_in_0  input  p_data_width  requester 0 write data
o_r_gnt_0  output  1  requester 0 grant pulse
o_r_rvalid_0  output  1  requester 0 read data valid pulse
i_w_req_1, i_w_we_1, i_w_address_1, i_w_in_1, o_r_gnt_1, o_r_rvalid_1  same as requester 0, for requester 1
o_w_rdata  output  p_data_width  read data, shared by both requesters, qualified by o_r_rvalid_n
o_r_ram_address  output  p_address_width  to cram i_w_address
o_r_ram_in  output  p_data_width  to cram i_w_in
o_r_ram_we  output  1  to cram i_w_we
o_r_ram_oe  output  1  to cram i_w_oe
i_w_ram_out  input  p_data_width  from cram o_w_out

Behaviour:
- Clock and reset: single clock i_w_clk; i_w_reset asynchronous, active-high.
- Reset values: all registered outputs 0; state IDLE; priority pointer = requester 0.
- Reset mid-operation: aborts the access immediately. ram_we drops asynchronously; no gnt or rvalid is issued.
- FSM states: IDLE, ACCESS, READ_DATA.
- IDLE, no request: stays in IDLE.
- IDLE, request present: selects a winner, registers address, data, we and the winner id, then goes to ACCESS.
  - Only one requester asserting req: that requester wins.
  - Both asserting req: the requester named by the priority pointer wins.
- ACCESS (1 cycle):
  - o_r_gnt_<winner>=1.
  - ram_address and ram_in hold the latched values.
  - Write: ram_we=1, ram_oe=0; next state IDLE.
  - Read: ram_we=0, ram_oe=1; next state READ_DATA.
  - Priority pointer toggles to the non-winner at the end of ACCESS.
- READ_DATA (1 cycle):
  - ram_oe=1, ram_address held, ram_we=0.
  - o_r_rvalid_<winner>=1.
  - o_w_rdata = i_w_ram_out (combinational pass-through); o_w_rdata = 0 in all other states.
  - Next state IDLE.
- Latency:
  - Write: gnt 1 cycle after request sampled; request-to-next-IDLE 2 cycles.
  - Read: rvalid 2 cycles after request sampled; 3 cycles per access.
- Handshake:
  - A requester holds req, we, address and data stable until it sees gnt.
  - The request is sampled only in IDLE, and fields are latched at that point.
  - Deasserting req before it is sampled in IDLE cancels it.
  - A requester still asserting req in the cycle after gnt is treated as a new request.
- Exclusivity:
  - gnt_0 and gnt_1 are never high together; the same applies to rvalid_0 and rvalid_1.
  - ram_we and ram_oe are never high together.
- Fairness: with both requesters continuously requesting, grants alternate strictly 0,1,0,1...
- No pipelining: a new request is not sampled during ACCESS or READ_DATA.

Optional Feature:
- Macro: CRAM_ARB_STATS_EN.
- Defined: adds outputs o_r_gnt_count_0 and o_r_gnt_count_1, each 16 bits.
  - Each counter increments on its requester's gnt pulse.
  - Saturates at 16'hFFFF.
  - Reset to 0 by i_w_reset.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released with no requests -> all outputs 0, state IDLE, no gnt for 10 cycles.
- Req0 writes 16'hBEEF at address 10'h005, then reads address 10'h005 -> gnt_0 one cycle after sampling with ram_we=1, address 10'h005 and ram_in 16'hBEEF; read gives rvalid_0 two cycles after sampling with o_w_rdata=16'hBEEF.
- Req0 and req1 both issue reads of addresses 10'h001 and 10'h002 in the same cycle after reset -> requester 0 served first, then requester 1; rvalid_0 carries mem[1] and rvalid_1 carries mem[2]; gnt never overlaps.
- Both requesters held continuously for 8 accesses -> gnt sequence 0,1,0,1,0,1,0,1; ram_we and ram_oe never high together.
- Reset asserted during the ACCESS cycle of a write to 10'h3FF with data 16'h1234 -> ram_we drops immediately; no gnt or rvalid; after release, a read of 10'h3FF returns the prior contents.
- With CRAM_ARB_STATS_EN defined: 5 grants to requester 0 and 3 to requester 1 -> gnt_count_0=5, gnt_count_1=3. Counter preloaded to 16'hFFFE, then 3 grants -> counter holds 16'hFFFF.
